// File: rtl/serial_comparator_sequencer_msb_first_if.sv
// Bundle of operand, serial and result signals around the MSB-first comparator
// sequencer. The slave side is the sequencer. The master side is whatever feeds
// operands, hosts the comparator and consumes results.
interface serial_comparator_sequencer_msb_first_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             ser_clear;
  logic             ser_a;
  logic             ser_b;
  logic             ser_last;
  logic             cmp_less;
  logic             cmp_eq;
  logic             cmp_greater;
  logic             res_valid;
  logic             res_ready;
  logic             res_less;
  logic             res_eq;
  logic             res_greater;
  logic             res_err;

  modport slave (
    input  in_valid, in_a, in_b, cmp_less, cmp_eq, cmp_greater, res_ready,
    output in_ready, ser_clear, ser_a, ser_b, ser_last,
           res_valid, res_less, res_eq, res_greater, res_err
  );

  modport master (
    output in_valid, in_a, in_b, cmp_less, cmp_eq, cmp_greater, res_ready,
    input  in_ready, ser_clear, ser_a, ser_b, ser_last,
           res_valid, res_less, res_eq, res_greater, res_err
  );
endinterface

// File: rtl/serial_comparator_sequencer_msb_first.sv
// Front-end sequencer for the MSB-first serial comparator. It takes an operand
// pair, sends a one-cycle clear to the comparator, and then streams both
// operands MSB first. It then returns the comparator flags as a parallel result.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | ready for an operand pair
// S_CLEAR | one-cycle synchronous clear pulse to the comparator
// S_SHIFT | WIDTH cycles streaming operand bits, MSB first
// S_HOLD  | result presented until the downstream side accepts it
module serial_comparator_sequencer_msb_first #(
  parameter int WIDTH = 8
) (
  input logic                                   clk,
  input logic                                   rst,
  serial_comparator_sequencer_msb_first_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SHIFT, S_HOLD} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic [CW-1:0]    cnt;
  logic             r_less, r_eq, r_greater, r_err;
  logic             accept, last, one_hot;

  assign accept  = (state == S_IDLE) && bus.in_valid;
  assign last    = (state == S_SHIFT) && (cnt == CNT_LAST);
  assign one_hot = ( bus.cmp_less && !bus.cmp_eq && !bus.cmp_greater) ||
                   (!bus.cmp_less &&  bus.cmp_eq && !bus.cmp_greater) ||
                   (!bus.cmp_less && !bus.cmp_eq &&  bus.cmp_greater);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_CLEAR;
      S_CLEAR: state_nxt = S_SHIFT;
      S_SHIFT: if (last) state_nxt = S_HOLD;
      S_HOLD:  if (bus.res_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand shift registers, bit counter and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_a      <= '0;
      sh_b      <= '0;
      cnt       <= '0;
      r_less    <= 1'b0;
      r_eq      <= 1'b0;
      r_greater <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            sh_a <= bus.in_a;
            sh_b <= bus.in_b;
          end
        end
        S_CLEAR: cnt <= '0;
        S_SHIFT: begin
          sh_a <= {sh_a[WIDTH-2:0], 1'b0};
          sh_b <= {sh_b[WIDTH-2:0], 1'b0};
          if (last) begin
            r_less    <= bus.cmp_less;
            r_eq      <= bus.cmp_eq;
            r_greater <= bus.cmp_greater;
            r_err     <= !one_hot;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = (state == S_IDLE);
  assign bus.ser_clear   = (state == S_CLEAR);
  assign bus.ser_a       = (state == S_SHIFT) && sh_a[WIDTH-1];
  assign bus.ser_b       = (state == S_SHIFT) && sh_b[WIDTH-1];
  assign bus.ser_last    = last;
  assign bus.res_valid   = (state == S_HOLD);
  assign bus.res_less    = r_less;
  assign bus.res_eq      = r_eq;
  assign bus.res_greater = r_greater;
  assign bus.res_err     = r_err;

endmodule

// File: tb/tb_serial_comparator_sequencer_msb_first.sv
// Directed bench for the MSB-first comparator sequencer. A behavioural serial
// comparator is attached. A stub mode can force non-one-hot flags on the
// ser_last cycle.
module tb_serial_comparator_sequencer_msb_first;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  bit   stub_mode = 1'b0;

  serial_comparator_sequencer_msb_first_if #(.WIDTH(W)) bus ();

  serial_comparator_sequencer_msb_first #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural comparator: it latches the first differing bit. Until a bit
  // differs, the flags follow the current bit pair.
  logic dec, dec_lt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec    <= 1'b0;
      dec_lt <= 1'b0;
    end else if (bus.ser_clear) begin
      dec    <= 1'b0;
      dec_lt <= 1'b0;
    end else if (!dec && (bus.ser_a != bus.ser_b)) begin
      dec    <= 1'b1;
      dec_lt <= bus.ser_b;
    end
  end

  always_comb begin
    bus.cmp_less    = 1'b0;
    bus.cmp_eq      = 1'b0;
    bus.cmp_greater = 1'b0;
    if (stub_mode) begin
      bus.cmp_less = bus.ser_last;
      bus.cmp_eq   = bus.ser_last;
    end else if (dec) begin
      bus.cmp_less    = dec_lt;
      bus.cmp_greater = !dec_lt;
    end else begin
      bus.cmp_less    = !bus.ser_a &&  bus.ser_b;
      bus.cmp_greater =  bus.ser_a && !bus.ser_b;
      bus.cmp_eq      = (bus.ser_a == bus.ser_b);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents an operand pair and returns one cycle after the accepting edge,
  // which is the CLEAR cycle.
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, output bit ok);
    ok = 1'b0;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 30; n++) begin
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
    end
    checks++;
    if ({bus.ser_clear, bus.ser_a, bus.ser_b, bus.ser_last} !== 4'b0000) begin
      errors++; $display("FAIL reset_ser got=%b exp=0000",
                         {bus.ser_clear, bus.ser_a, bus.ser_b, bus.ser_last});
    end
    checks++;
    if ({bus.res_valid, bus.res_less, bus.res_eq, bus.res_greater, bus.res_err} !== 5'b00000) begin
      errors++; $display("FAIL reset_res got=%b exp=00000",
                         {bus.res_valid, bus.res_less, bus.res_eq, bus.res_greater, bus.res_err});
    end
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_compare_vectors();
    logic [W-1:0] va [3];
    logic [W-1:0] vb [3];
    logic [2:0]   vexp [3];   // {less, eq, greater}
    logic [W-1:0] a, b;
    bit ok;
    va[0] = 8'h5A; vb[0] = 8'h5A; vexp[0] = 3'b010;
    va[1] = 8'h80; vb[1] = 8'h7F; vexp[1] = 3'b001;
    va[2] = 8'h12; vb[2] = 8'h13; vexp[2] = 3'b100;
    bus.res_ready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      a = va[v];
      b = vb[v];
      accept(a, b, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL vec%0d_accept_timeout got=0 exp=1", v); end
      checks++;
      if ({bus.ser_clear, bus.ser_a, bus.ser_b, bus.in_ready} !== 4'b1000) begin
        errors++; $display("FAIL vec%0d_clear got=%b exp=1000", v,
                           {bus.ser_clear, bus.ser_a, bus.ser_b, bus.in_ready});
      end
      for (int k = 0; k < W; k++) begin
        step();
        checks++;
        if ({bus.ser_a, bus.ser_b, bus.ser_last} !== {a[W-1-k], b[W-1-k], (k == W-1)}) begin
          errors++; $display("FAIL vec%0d_bit%0d got=%b exp=%b", v, k,
                             {bus.ser_a, bus.ser_b, bus.ser_last},
                             {a[W-1-k], b[W-1-k], (k == W-1)});
        end
      end
      step();
      checks++;
      if ({bus.res_valid, bus.res_less, bus.res_eq, bus.res_greater, bus.res_err} !== {1'b1, vexp[v], 1'b0}) begin
        errors++; $display("FAIL vec%0d_result got=%b exp=%b", v,
                           {bus.res_valid, bus.res_less, bus.res_eq, bus.res_greater, bus.res_err},
                           {1'b1, vexp[v], 1'b0});
      end
      step();
      checks++;
      if ({bus.in_ready, bus.res_valid} !== 2'b10) begin
        errors++; $display("FAIL vec%0d_idle got=%b exp=10", v, {bus.in_ready, bus.res_valid});
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bus.res_ready = 1'b0;
    accept(8'h33, 8'h44, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_accept_timeout got=0 exp=1"); end
    for (int k = 0; k < W + 1; k++) step();
    bus.in_valid = 1'b1;
    bus.in_a     = 8'hFF;
    bus.in_b     = 8'h00;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({bus.res_valid, bus.in_ready, bus.res_less, bus.res_eq, bus.res_greater, bus.res_err} !== 6'b101000) begin
        errors++; $display("FAIL bp_hold%0d got=%b exp=101000", c,
                           {bus.res_valid, bus.in_ready, bus.res_less, bus.res_eq, bus.res_greater, bus.res_err});
      end
      step();
    end
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b1;
    checks++;
    if ({bus.res_valid, bus.res_less} !== 2'b11) begin
      errors++; $display("FAIL bp_release got=%b exp=11", {bus.res_valid, bus.res_less});
    end
    step();
    checks++;
    if ({bus.in_ready, bus.res_valid} !== 2'b10) begin
      errors++; $display("FAIL bp_idle got=%b exp=10", {bus.in_ready, bus.res_valid});
    end
  endtask

  task automatic test_back_to_back();
    int first, second, cyc;
    first  = -1;
    second = -1;
    bus.res_ready = 1'b1;
    bus.in_a      = 8'h10;
    bus.in_b      = 8'h20;
    bus.in_valid  = 1'b1;
    for (cyc = 0; cyc < 40; cyc++) begin
      if (bus.in_ready && bus.in_valid) begin
        if (first < 0) first = cyc;
        else if (second < 0) second = cyc;
      end
      step();
    end
    bus.in_valid = 1'b0;
    checks++;
    if ((first < 0) || (second < 0) || (second - first !== W + 3)) begin
      errors++; $display("FAIL b2b_period got=%0d exp=%0d", second - first, W + 3);
    end
    for (int n = 0; n < 30 && !bus.in_ready; n++) step();
  endtask

  task automatic test_in_valid_hold();
    logic [W-1:0] a, b;
    bit ok;
    a = 8'hC3;
    b = 8'h3C;
    bus.res_ready = 1'b1;
    accept(a, b, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ivh_accept_timeout got=0 exp=1"); end
    bus.in_valid = 1'b1;
    for (int k = 0; k < W; k++) begin
      bus.in_a = 8'h00 + 8'(k);
      bus.in_b = 8'hFF;
      step();
      checks++;
      if ({bus.ser_a, bus.ser_b, bus.in_ready} !== {a[W-1-k], b[W-1-k], 1'b0}) begin
        errors++; $display("FAIL ivh_bit%0d got=%b exp=%b", k,
                           {bus.ser_a, bus.ser_b, bus.in_ready}, {a[W-1-k], b[W-1-k], 1'b0});
      end
    end
    step();
    bus.in_valid = 1'b0;
    checks++;
    if ({bus.res_valid, bus.res_less, bus.res_eq, bus.res_greater, bus.res_err} !== 5'b10010) begin
      errors++; $display("FAIL ivh_result got=%b exp=10010",
                         {bus.res_valid, bus.res_less, bus.res_eq, bus.res_greater, bus.res_err});
    end
    step();
  endtask

  task automatic test_reset_mid_shift();
    bit ok;
    bit seen_valid;
    bus.res_ready = 1'b1;
    accept(8'hFF, 8'h00, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rms_accept_timeout got=0 exp=1"); end
    for (int k = 0; k < 5; k++) step();
    checks++;
    if ({bus.ser_a, bus.ser_b} !== 2'b10) begin
      errors++; $display("FAIL rms_bit4 got=%b exp=10", {bus.ser_a, bus.ser_b});
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.in_ready, bus.ser_clear, bus.ser_a, bus.ser_b, bus.ser_last, bus.res_valid} !== 6'b100000) begin
      errors++; $display("FAIL rms_async got=%b exp=100000",
                         {bus.in_ready, bus.ser_clear, bus.ser_a, bus.ser_b, bus.ser_last, bus.res_valid});
    end
    step();
    step();
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (bus.res_valid) seen_valid = 1'b1;
      step();
    end
    checks++;
    if (seen_valid !== 1'b0) begin
      errors++; $display("FAIL rms_no_result got=%b exp=0", seen_valid);
    end
    accept(8'h01, 8'h02, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rms_accept2_timeout got=0 exp=1"); end
    for (int k = 0; k < W + 1; k++) step();
    checks++;
    if ({bus.res_valid, bus.res_less, bus.res_eq, bus.res_greater, bus.res_err} !== 5'b11000) begin
      errors++; $display("FAIL rms_result got=%b exp=11000",
                         {bus.res_valid, bus.res_less, bus.res_eq, bus.res_greater, bus.res_err});
    end
    step();
  endtask

  task automatic test_err_flag();
    bit ok;
    bus.res_ready = 1'b1;
    stub_mode = 1'b1;
    accept(8'hA5, 8'h0F, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL err_accept_timeout got=0 exp=1"); end
    for (int k = 0; k < W + 1; k++) step();
    checks++;
    if ({bus.res_valid, bus.res_less, bus.res_eq, bus.res_greater, bus.res_err} !== 5'b11101) begin
      errors++; $display("FAIL err_result got=%b exp=11101",
                         {bus.res_valid, bus.res_less, bus.res_eq, bus.res_greater, bus.res_err});
    end
    stub_mode = 1'b0;
    step();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.res_ready = 1'b0;
    #1;
    test_reset();
    test_compare_vectors();
    test_backpressure();
    test_back_to_back();
    test_in_valid_hold();
    test_reset_mid_shift();
    test_err_flag();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_comparator_sequencer_msb_first.md
# serial_comparator_sequencer_msb_first

Front-end sequencer for the MSB-first serial comparator. It accepts a pair of parallel WIDTH-bit operands over a valid/ready handshake, issues a one-cycle clear pulse to the comparator, and streams both operands MSB first, one bit per cycle. On the last bit it captures the comparator's three flags and returns them as a parallel result over a second valid/ready handshake. It sits directly upstream of the comparator, drives its `rst`, `a` and `b`, and consumes its `a_less_b`, `a_eq_b` and `a_greater_b`.

## Interface
- `WIDTH`, default 8: operand width in bits; legal range is WIDTH ≥ 2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: operand pair is valid.
- `in_ready` out 1: sequencer can accept an operand pair.
- `in_a` in WIDTH: operand A.
- `in_b` in WIDTH: operand B.
- `ser_clear` out 1: synchronous clear to the comparator's `rst`.
- `ser_a` out 1: serial bit of A, MSB first.
- `ser_b` out 1: serial bit of B, MSB first.
- `ser_last` out 1: high while the LSB is on `ser_a`/`ser_b`.
- `cmp_less` in 1: comparator flag `a_less_b`.
- `cmp_eq` in 1: comparator flag `a_eq_b`.
- `cmp_greater` in 1: comparator flag `a_greater_b`.
- `res_valid` out 1: result is valid.
- `res_ready` in 1: downstream accepts the result.
- `res_less`, `res_eq`, `res_greater` out 1 each: captured comparator flags.
- `res_err` out 1: captured flags were not one-hot.

## Operation
- FSM has four states: IDLE, CLEAR, SHIFT, HOLD.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&`in_ready`, load `in_a` and `in_b` into shift registers, then go to CLEAR.
- CLEAR (exactly 1 cycle):
  - `ser_clear`=1; `ser_a`=`ser_b`=0.
  - Clear the bit counter; go to SHIFT.
- SHIFT (exactly WIDTH cycles):
  - `ser_a`/`ser_b` = MSB of their shift registers; both registers shift left by 1 each cycle.
  - Counter increments 0..WIDTH-1; `ser_last`=1 when counter = WIDTH-1.
  - At the edge ending the `ser_last` cycle:
    - capture `cmp_less`/`cmp_eq`/`cmp_greater` into `res_*`;
    - set `res_err` = NOT(exactly one flag set);
    - go to HOLD.
- HOLD:
  - `res_valid`=1; `res_*` and `res_err` stay stable.
  - On `res_valid`&`res_ready`, go to IDLE.
- `in_ready`=0 in CLEAR, SHIFT and HOLD. `in_valid` in those states is ignored and operands are not sampled.
- `ser_clear`, `ser_last`, `ser_a` and `ser_b` are 0 outside the states named above.
- All outputs are registered or decoded from state and registers only. No combinational path from `cmp_*` to any output.

## Timing
- Reset (asynchronous, any state, including mid-SHIFT or mid-HOLD):
  - state goes to IDLE;
  - `in_ready`=1;
  - every other output is 0, including `res_*` and `res_err`;
  - shift registers and counter are cleared;
  - any in-flight compare is discarded without a result.
- Accept handshake at edge E (cycle t ends):
  - t+1: CLEAR.
  - t+2+k, for k=0..WIDTH-1: `ser_a` = `in_a[WIDTH-1-k]`, `ser_b` = `in_b[WIDTH-1-k]`.
  - t+1+WIDTH: `ser_last`=1.
  - t+2+WIDTH: `res_valid`=1.
- Latency from accept to `res_valid` is WIDTH+2 cycles.
- Minimum period between accepts is WIDTH+3 cycles, reached with `res_ready` held at 1.
- `res_ready` asserted before `res_valid` has no effect.
- HOLD persists indefinitely while `res_ready`=0.
- Counter width is $clog2(WIDTH). No wrap beyond WIDTH-1, because the FSM leaves SHIFT there.

## Test plan
- WIDTH=8, `in_a`=8'h5A, `in_b`=8'h5A, `res_ready`=1, real comparator attached:
  - `ser_a` sequence 0,1,0,1,1,0,1,0;
  - `res_eq`=1, `res_less`=0, `res_greater`=0, `res_err`=0 at accept+10.
- `in_a`=8'h80, `in_b`=8'h7F → `res_greater`=1. `in_a`=8'h12, `in_b`=8'h13 → `res_less`=1.
- Backpressure: `res_ready`=0 for 5 cycles after `res_valid`.
  - `res_*` stays stable and `in_ready`=0 throughout.
  - With `res_ready`=1, return to IDLE next cycle; next accept no earlier than accept+11.
- `in_valid` held high with changing `in_a` during SHIFT:
  - serial stream and result reflect only the operand pair accepted in IDLE.
- Assert `rst` during SHIFT at bit 4:
  - outputs go to reset values immediately;
  - no `res_valid`;
  - the next compare of 8'h01 vs 8'h02 gives `res_less`=1.
- Comparator stub drives `cmp_less`=`cmp_eq`=1 on the `ser_last` cycle → `res_err`=1, flags captured as driven.
